// File: rtl/csr_fifo_bridge.sv
// CSR req/ack port bridged onto per-channel TX (CSR -> HW) and RX (HW -> CSR) queues,
// with a bounded stall timeout and error qualification on every ack.

module csr_fifo_bridge_q #(
  parameter int Width = 32,
  parameter int Depth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic [$clog2(Depth+1)-1:0]   cnt_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;

  // Callers gate push on not-full and pop on not-empty; a flush wins over both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;
endmodule

module csr_fifo_bridge #(
  parameter int NumCh         = 2,
  parameter int Width         = 32,
  parameter int Depth         = 64,
  parameter int TimeoutCycles = 256,
  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1,
  localparam int DW  = $clog2(Depth+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   req_is_wr_i,
  input  logic [ChW-1:0]         ch_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic [Width-1:0]       wr_biten_i,
  output logic                   wr_ack_o,
  output logic                   rd_ack_o,
  output logic [Width-1:0]       rd_data_o,
  output logic                   err_o,
  input  logic [NumCh-1:0]       clr_i,
  output logic [NumCh-1:0]       tx_valid_o,
  input  logic [NumCh-1:0]       tx_ready_i,
  output logic [NumCh*Width-1:0] tx_data_o,
  input  logic [NumCh-1:0]       rx_valid_i,
  output logic [NumCh-1:0]       rx_ready_o,
  input  logic [NumCh*Width-1:0] rx_data_i,
  output logic [NumCh*DW-1:0]    tx_depth_o,
  output logic [NumCh*DW-1:0]    rx_depth_o,
  output logic                   timeout_o
);
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles+1) : 1;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e           state_q;
  logic             wr_q;
  logic [ChW-1:0]   ch_q;
  logic [Width-1:0] data_q;
  logic [Width-1:0] biten_q;
  logic [TW-1:0]    stall_q;

  logic [NumCh-1:0][DW-1:0]    tx_cnt, rx_cnt;
  logic [NumCh-1:0][Width-1:0] tx_head, rx_head, rx_din;
  logic [NumCh-1:0]            tx_push, tx_pop, rx_push, rx_pop;

  logic           serve, ch_ok, imm_err, go, tmo, ack;
  logic [ChW-1:0] ch_idx;

  assign serve   = (state_q == SERVE);
  assign ch_ok   = (int'(ch_q) < NumCh);
  assign ch_idx  = ch_ok ? ch_q : '0;
  assign imm_err = !ch_ok || (wr_q && (biten_q != '1));

  // Only registered occupancy is consulted, and a flush on the target channel
  // holds the request so it is re-evaluated against the emptied queues.
  assign go  = serve && !imm_err && !clr_i[ch_idx] &&
               (wr_q ? (tx_cnt[ch_idx] != DW'(Depth)) : (rx_cnt[ch_idx] != '0));
  assign tmo = serve && !imm_err && !go && (TimeoutCycles != 0) &&
               (stall_q == TW'(TimeoutCycles));
  assign ack = serve && (imm_err || go || tmo);

  assign wr_ack_o  = ack && wr_q;
  assign rd_ack_o  = ack && !wr_q;
  assign err_o     = ack && !go;
  assign timeout_o = tmo;
  assign rd_data_o = (go && !wr_q) ? rx_head[ch_idx] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      biten_q <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            wr_q    <= req_is_wr_i;
            ch_q    <= ch_i;
            data_q  <= wr_data_i;
            biten_q <= wr_biten_i;
            stall_q <= '0;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          if (ack) begin
            state_q <= IDLE;
          end else if ((TimeoutCycles != 0) && (stall_q != TW'(TimeoutCycles))) begin
            stall_q <= stall_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_din = rx_data_i;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    assign tx_push[c] = go && wr_q && (ch_idx == ChW'(c));
    assign tx_pop[c]  = tx_ready_i[c] && (tx_cnt[c] != '0);
    assign rx_push[c] = rx_valid_i[c] && (rx_cnt[c] != DW'(Depth));
    assign rx_pop[c]  = go && !wr_q && (ch_idx == ChW'(c));

    csr_fifo_bridge_q #(.Width(Width), .Depth(Depth)) u_tx (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i[c]),
      .push_i(tx_push[c]), .push_data_i(data_q), .pop_i(tx_pop[c]),
      .head_o(tx_head[c]), .cnt_o(tx_cnt[c])
    );

    csr_fifo_bridge_q #(.Width(Width), .Depth(Depth)) u_rx (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i[c]),
      .push_i(rx_push[c]), .push_data_i(rx_din[c]), .pop_i(rx_pop[c]),
      .head_o(rx_head[c]), .cnt_o(rx_cnt[c])
    );

    assign tx_valid_o[c] = (tx_cnt[c] != '0);
    assign rx_ready_o[c] = (rx_cnt[c] != DW'(Depth));
  end

  assign tx_data_o  = tx_head;
  assign tx_depth_o = tx_cnt;
  assign rx_depth_o = rx_cnt;
endmodule

// File: tb/tb_csr_fifo_bridge.sv
// Directed bench for csr_fifo_bridge: 3 channels so an out-of-range channel index is encodable.

module tb_csr_fifo_bridge;
  localparam int DW = 7;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0, req_is_wr_i = 1'b0;
  logic [1:0]  ch_i = '0;
  logic [31:0] wr_data_i = '0, wr_biten_i = '0;
  logic        wr_ack_o, rd_ack_o, err_o, timeout_o;
  logic [31:0] rd_data_o;
  logic [2:0]  clr_i = '0, tx_ready_i = '0, rx_valid_i = '0;
  logic [2:0]  tx_valid_o, rx_ready_o;
  logic [95:0] tx_data_o, rx_data_i = '0;
  logic [20:0] tx_depth_o, rx_depth_o;

  int nvec = 0, nerr = 0;

  csr_fifo_bridge #(.NumCh(3), .Width(32), .Depth(64), .TimeoutCycles(256)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_is_wr_i(req_is_wr_i), .ch_i(ch_i),
    .wr_data_i(wr_data_i), .wr_biten_i(wr_biten_i), .wr_ack_o(wr_ack_o), .rd_ack_o(rd_ack_o),
    .rd_data_o(rd_data_o), .err_o(err_o), .clr_i(clr_i), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i), .tx_depth_o(tx_depth_o),
    .rx_depth_o(rx_depth_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle request; returns in the cycle after the request cycle.
  task automatic issue(input logic wr, input logic [1:0] ch, input logic [31:0] d, input logic [31:0] be);
    @(posedge clk); #1;
    req_i = 1'b1; req_is_wr_i = wr; ch_i = ch; wr_data_i = d; wr_biten_i = be;
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  // Latency 1 = the cycle after the request; lat = -1 when no ack within maxc cycles.
  task automatic wait_ack(input int maxc, input int pulse_at, input int pch,
                          output int lat, output logic err, output logic tmo, output logic [31:0] rd);
    bit got = 0;
    lat = 1; err = 1'bx; tmo = 1'bx; rd = 'x;
    while (!got && lat <= maxc) begin
      if (lat == pulse_at) tx_ready_i[pch] = 1'b1;
      @(negedge clk);
      if (wr_ack_o || rd_ack_o) begin
        got = 1; err = err_o; tmo = timeout_o; rd = rd_data_o;
      end else begin
        @(posedge clk); #1;
        tx_ready_i = '0;
        lat++;
      end
    end
    tx_ready_i = '0;
    if (!got) lat = -1;
  endtask

  task automatic next_cycle_sample();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if ({wr_ack_o, rd_ack_o, err_o, timeout_o} !== 4'b0) begin nerr++; $display("FAIL reset_acks: got %b want 0000", {wr_ack_o, rd_ack_o, err_o, timeout_o}); end
    nvec++; if (rd_data_o !== 32'h0) begin nerr++; $display("FAIL reset_rd_data: got %h want 0", rd_data_o); end
    nvec++; if (tx_valid_o !== 3'b000) begin nerr++; $display("FAIL reset_tx_valid: got %b want 000", tx_valid_o); end
    nvec++; if (rx_ready_o !== 3'b111) begin nerr++; $display("FAIL reset_rx_ready: got %b want 111", rx_ready_o); end
    nvec++; if ({tx_depth_o, rx_depth_o} !== 42'h0) begin nerr++; $display("FAIL reset_depths: got %h/%h want 0", tx_depth_o, rx_depth_o); end
    @(posedge clk); #1; rst_i = 1'b0;
  endtask

  task automatic test_write_basic();
    int lat; logic e, t; logic [31:0] rd;
    issue(1'b1, 2'd0, 32'hDEADBEEF, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 1 || e !== 1'b0 || t !== 1'b0) begin nerr++; $display("FAIL wr_basic_ack: got lat %0d err %b tmo %b want 1 0 0", lat, e, t); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[0 +: DW] !== 7'd1) begin nerr++; $display("FAIL wr_basic_depth: got %0d want 1", tx_depth_o[0 +: DW]); end
    nvec++; if (tx_data_o[0 +: 32] !== 32'hDEADBEEF || tx_valid_o[0] !== 1'b1) begin nerr++; $display("FAIL wr_basic_head: got %h valid %b want deadbeef 1", tx_data_o[0 +: 32], tx_valid_o[0]); end
    @(posedge clk); #1; tx_ready_i[0] = 1'b1;
    @(posedge clk); #1; tx_ready_i[0] = 1'b0;
    @(negedge clk);
    nvec++; if (tx_depth_o[0 +: DW] !== 7'd0 || tx_valid_o[0] !== 1'b0) begin nerr++; $display("FAIL wr_basic_drain: got %0d want 0", tx_depth_o[0 +: DW]); end
  endtask

  task automatic test_fill_timeout();
    int lat, bad = 0; logic e, t; logic [31:0] rd;
    for (int i = 0; i < 64; i++) begin
      issue(1'b1, 2'd1, 32'h100 + i, 32'hFFFFFFFF);
      wait_ack(400, 0, 0, lat, e, t, rd);
      if (lat != 1 || e !== 1'b0) bad++;
    end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL fill_writes: got %0d bad acks want 0", bad); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[DW +: DW] !== 7'd64 || rx_ready_o !== 3'b111) begin nerr++; $display("FAIL fill_depth: got %0d want 64", tx_depth_o[DW +: DW]); end
    issue(1'b1, 2'd1, 32'hBAD0BAD0, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 257 || e !== 1'b1 || t !== 1'b1) begin nerr++; $display("FAIL fill_timeout: got lat %0d err %b tmo %b want 257 1 1", lat, e, t); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[DW +: DW] !== 7'd64 || tx_data_o[32 +: 32] !== 32'h100) begin nerr++; $display("FAIL fill_after_to: got %0d %h want 64 00000100", tx_depth_o[DW +: DW], tx_data_o[32 +: 32]); end
  endtask

  task automatic test_stall_release();
    int lat; logic e, t; logic [31:0] rd;
    issue(1'b1, 2'd1, 32'hCAFE0001, 32'hFFFFFFFF);
    wait_ack(400, 10, 1, lat, e, t, rd);
    nvec++; if (lat !== 11 || e !== 1'b0 || t !== 1'b0) begin nerr++; $display("FAIL stall_release: got lat %0d err %b tmo %b want 11 0 0", lat, e, t); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[DW +: DW] !== 7'd64 || tx_data_o[32 +: 32] !== 32'h101) begin nerr++; $display("FAIL stall_depth: got %0d %h want 64 00000101", tx_depth_o[DW +: DW], tx_data_o[32 +: 32]); end
    @(posedge clk); #1; tx_ready_i[1] = 1'b1;
    repeat (70) @(posedge clk);
    #1; tx_ready_i[1] = 1'b0;
    @(negedge clk);
    nvec++; if (tx_depth_o[DW +: DW] !== 7'd0) begin nerr++; $display("FAIL stall_drain: got %0d want 0", tx_depth_o[DW +: DW]); end
  endtask

  task automatic test_rx_order();
    int lat; logic e, t; logic [31:0] rd;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1; rx_valid_i[0] = 1'b1; rx_data_i[0 +: 32] = 32'(i);
    end
    @(posedge clk); #1; rx_valid_i = '0;
    @(negedge clk);
    nvec++; if (rx_depth_o[0 +: DW] !== 7'd3) begin nerr++; $display("FAIL rx_depth: got %0d want 3", rx_depth_o[0 +: DW]); end
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 2'd0, 32'h0, 32'h0);
      wait_ack(400, 0, 0, lat, e, t, rd);
      nvec++; if (lat !== 1 || e !== 1'b0 || rd !== 32'(i)) begin nerr++; $display("FAIL rx_read%0d: got lat %0d err %b data %h want 1 0 %h", i, lat, e, rd, 32'(i)); end
    end
    issue(1'b0, 2'd0, 32'h0, 32'h0);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 257 || e !== 1'b1 || t !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL rx_empty_to: got lat %0d err %b tmo %b data %h want 257 1 1 0", lat, e, t, rd); end
  endtask

  task automatic test_errors();
    int lat; logic e, t; logic [31:0] rd;
    issue(1'b1, 2'd3, 32'h12345678, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 1 || e !== 1'b1 || t !== 1'b0) begin nerr++; $display("FAIL err_bad_ch_wr: got lat %0d err %b tmo %b want 1 1 0", lat, e, t); end
    issue(1'b1, 2'd0, 32'h12345678, 32'h0000FFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 1 || e !== 1'b1 || t !== 1'b0) begin nerr++; $display("FAIL err_biten: got lat %0d err %b tmo %b want 1 1 0", lat, e, t); end
    issue(1'b0, 2'd3, 32'h0, 32'h0);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL err_bad_ch_rd: got lat %0d err %b data %h want 1 1 0", lat, e, rd); end
    next_cycle_sample();
    nvec++; if ({tx_depth_o, rx_depth_o} !== 42'h0) begin nerr++; $display("FAIL err_depths: got %h/%h want 0", tx_depth_o, rx_depth_o); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic e1, e2, t; logic [31:0] rd;
    issue(1'b1, 2'd2, 32'hA0000001, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat1, e1, t, rd);
    issue(1'b1, 2'd2, 32'hA0000002, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat2, e2, t, rd);
    nvec++; if (lat1 !== 1 || lat2 !== 1 || e1 !== 1'b0 || e2 !== 1'b0) begin nerr++; $display("FAIL b2b_acks: got lat %0d/%0d err %b/%b want 1/1 0/0", lat1, lat2, e1, e2); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[2*DW +: DW] !== 7'd2 || tx_data_o[64 +: 32] !== 32'hA0000001) begin nerr++; $display("FAIL b2b_depth: got %0d %h want 2 a0000001", tx_depth_o[2*DW +: DW], tx_data_o[64 +: 32]); end
  endtask

  task automatic test_clr_reset();
    int lat, acks = 0; logic e, t; logic [31:0] rd;
    issue(1'b1, 2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    @(posedge clk); #1; rx_valid_i = 3'b100; rx_data_i[64 +: 32] = 32'd77;
    @(posedge clk); #1; rx_valid_i = '0;
    issue(1'b0, 2'd0, 32'h0, 32'h0);
    repeat (4) begin @(negedge clk); if (wr_ack_o || rd_ack_o) acks++; @(posedge clk); #1; end
    clr_i = 3'b001;
    @(negedge clk); if (wr_ack_o || rd_ack_o) acks++;
    @(posedge clk); #1; clr_i = '0;
    @(negedge clk); if (wr_ack_o || rd_ack_o) acks++;
    nvec++; if (tx_depth_o[0 +: DW] !== 7'd0 || tx_depth_o[2*DW +: DW] !== 7'd2 || rx_depth_o[2*DW +: DW] !== 7'd1) begin nerr++; $display("FAIL clr_depths: got tx %h rx %h want ch0 0, tx2 2, rx2 1", tx_depth_o, rx_depth_o); end
    @(posedge clk); #1; rst_i = 1'b1;
    @(negedge clk); if (wr_ack_o || rd_ack_o) acks++;
    @(posedge clk); #1; rst_i = 1'b0;
    repeat (300) begin @(negedge clk); if (wr_ack_o || rd_ack_o) acks++; @(posedge clk); end
    @(negedge clk);
    nvec++; if (acks !== 0) begin nerr++; $display("FAIL rst_no_ack: got %0d acks want 0", acks); end
    nvec++; if ({tx_depth_o, rx_depth_o} !== 42'h0 || rx_ready_o !== 3'b111) begin nerr++; $display("FAIL rst_depths: got %h/%h want 0", tx_depth_o, rx_depth_o); end
    issue(1'b1, 2'd1, 32'h5A5A5A5A, 32'hFFFFFFFF);
    wait_ack(400, 0, 0, lat, e, t, rd);
    nvec++; if (lat !== 1 || e !== 1'b0) begin nerr++; $display("FAIL post_rst_wr: got lat %0d err %b want 1 0", lat, e); end
    next_cycle_sample();
    nvec++; if (tx_depth_o[DW +: DW] !== 7'd1 || tx_data_o[32 +: 32] !== 32'h5A5A5A5A) begin nerr++; $display("FAIL post_rst_head: got %0d %h want 1 5a5a5a5a", tx_depth_o[DW +: DW], tx_data_o[32 +: 32]); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_fill_timeout();
    test_stall_release();
    test_rx_order();
    test_errors();
    test_back_to_back();
    test_clr_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/csr_fifo_bridge.md
# csr_fifo_bridge

Parametrised multi-channel bridge between a PeakRDL external-register CSR port (req/ack) and hardware streaming queues. Each channel has a TX queue filled by CSR writes and drained by hardware, and an RX queue filled by hardware and drained by CSR reads. It replaces single-FIFO indirect-data hookups (e.g. recovery INDIRECT_FIFO_DATA) with configurable width, depth, channel count, bounded stall timeout and error signalling. It sits between `I3CCSR` hwif external registers and the core datapath queues.

## Interface
- `NumCh`, 2, number of channels (1..8)
- `Width`, 32, data width of the CSR port and of every queue entry (multiple of 8)
- `Depth`, 64, entries per queue (power of two, ≥2)
- `TimeoutCycles`, 256, maximum stall before error-ack; 0 = stall forever
- `clk_i` in 1, clock
- `rst_i` in 1, reset: asynchronous, active-high
- `req_i` in 1, single-cycle CSR request pulse
- `req_is_wr_i` in 1, 1 = write (TX push), 0 = read (RX pop)
- `ch_i` in $clog2(NumCh) (min 1), channel index, valid with `req_i`
- `wr_data_i` in Width, write data
- `wr_biten_i` in Width, write bit enables
- `wr_ack_o` out 1, write completion pulse
- `rd_ack_o` out 1, read completion pulse
- `rd_data_o` out Width, read data, valid only with `rd_ack_o`, else 0
- `err_o` out 1, error qualifier, valid only with an ack
- `clr_i` in NumCh, per-channel synchronous flush of both queues
- `tx_valid_o` out NumCh, TX entry available
- `tx_ready_i` in NumCh, hardware pops TX
- `tx_data_o` out NumCh*Width, TX head, channel c at [c*Width +: Width]
- `rx_valid_i` in NumCh, hardware pushes RX
- `rx_ready_o` out NumCh, RX not full
- `rx_data_i` in NumCh*Width, RX push data
- `tx_depth_o`, `rx_depth_o` out NumCh*$clog2(Depth+1), per-queue occupancy
- `timeout_o` out 1, pulse when a request ends by timeout

## Operation
- Reset: queues empty, all depths 0, FSM IDLE, all acks/err/timeout 0, `rd_data_o` 0, `tx_valid_o` 0, `rx_ready_o` all 1.
- FSM: IDLE, SERVE. IDLE + `req_i` → capture wr flag, channel, data, biten; → SERVE. SERVE returns to IDLE in the cycle an ack is issued.
- Immediate error (first SERVE cycle, ack with `err_o`=1, no queue access): `ch_i` ≥ NumCh; write with `wr_biten_i` not all-ones.
- SERVE write: if TX[ch] not full → push, `wr_ack_o`=1, `err_o`=0. Else stall.
- SERVE read: if RX[ch] not empty → pop, `rd_ack_o`=1, `rd_data_o`=head, `err_o`=0. Else stall.
- Stall counter counts SERVE cycles; at TimeoutCycles stalled cycles → ack with `err_o`=1, `timeout_o`=1, write data dropped, `rd_data_o`=0. TimeoutCycles=0: never times out.
- `req_i` while in SERVE: protocol violation, ignored, no ack.
- Full/empty decisions use registered occupancy only: no fall-through. A hardware pop from a full TX, or push into an empty RX, in the same cycle does not unblock the pending request until the next cycle.
- Simultaneous CSR push and HW pop on one TX queue (or HW push and CSR pop on RX): both take effect, depth unchanged.
- `clr_i[c]`: next cycle both queues of c empty; same-cycle pushes/pops on c discarded; pending request on c keeps waiting and is re-evaluated against the flushed state.
- `rx_valid_i` while `rx_ready_o`=0: entry dropped, no state change.
- Pointers wrap modulo Depth; occupancy 0..Depth inclusive.
- Reset mid-request: pending request discarded, no ack ever issued.

## Timing
- Non-stalled access: `req_i` cycle N → ack in cycle N+1 (1-cycle latency). Acks are single-cycle pulses.
- Timeout: ack at cycle N+1+TimeoutCycles when blocked throughout.
- Back-to-back: next `req_i` accepted in the ack cycle+1 (IDLE); earliest throughput one access per 2 cycles.
- `tx_data_o`, `tx_valid_o`, `rx_ready_o`, depths driven from registers; update cycle after the causing event.

## Test plan
- Reset: all outputs at reset values; write ch0 0xDEADBEEF → `wr_ack_o` at N+1, `tx_depth_o`[ch0]=1, `tx_data_o`[ch0]=0xDEADBEEF.
- Fill TX ch1 with 64 writes, 65th write with TimeoutCycles=256 → ack+`err_o`+`timeout_o` exactly 257 cycles after req; depth stays 64.
- 65th write stalled, pulse `tx_ready_i`[1] at stall cycle 10 → `wr_ack_o`, `err_o`=0, at stall cycle 11; depth 64.
- RX ch0: push 0x1,0x2,0x3 via `rx_valid_i` → three reads return 0x1,0x2,0x3 in order; fourth read empty → timeout error, `rd_data_o`=0.
- Errors: `ch_i`=NumCh, or write biten 0x0000FFFF → ack with `err_o`=1 at N+1, no depth change.
- Pending read on ch0, assert `clr_i`[0] and `rst_i` mid-stall → no ack, all depths 0, FSM IDLE; next write accepted normally.
